// File: rtl/avmm_chk_pkg.sv
// Shared types and helpers for the Avalon-MM write-sink checker.
// Pattern arithmetic is modulo (cnt_max + 1) so non-power-of-two wraps also work.
package avmm_chk_pkg;

  typedef enum logic [1:0] {
    WAIT_NONE  = 2'd0,
    WAIT_FIXED = 2'd1,
    WAIT_RAND  = 2'd2,
    WAIT_RSVD  = 2'd3
  } wait_mode_t;

  // Right-shifting Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [31:0] exp_lane(input logic [31:0] ref_v,
                                           input logic [31:0] idx,
                                           input logic [31:0] cnt_max);
    logic [32:0] sum;
    logic [32:0] modulus;
    sum     = {1'b0, ref_v} + {1'b0, idx};
    modulus = {1'b0, cnt_max} + 33'd1;
    if (sum >= modulus) sum = sum - modulus;
    return sum[31:0];
  endfunction

  function automatic logic [31:0] halfswap32(input logic [31:0] w);
    return {w[15:0], w[31:16]};
  endfunction

endpackage

// File: rtl/avmm_wait_gen.sv
// WAITREQUEST generator: free-running LFSR plus an IDLE/STALL counter FSM.
// A stall of len cycles starts the cycle after each accepted beat.
module avmm_wait_gen
  import avmm_chk_pkg::*;
#(
  parameter int          WAIT_MIN  = 10,
  parameter logic [7:0]  RAND_MASK = 8'h7F,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept,
  input  wait_mode_t mode,
  input  logic [7:0] len,
  output logic       waitrequest
);

  localparam int CNT_W = 9;

  typedef enum logic {ST_IDLE, ST_STALL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   load_len;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    lfsr_d   = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_len = '0;

    case (mode)
      WAIT_FIXED: load_len = CNT_W'(len);
      WAIT_RAND:  load_len = CNT_W'(WAIT_MIN) + CNT_W'(lfsr_q[7:0] & RAND_MASK);
      default:    load_len = '0;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d = load_len;
          if (load_len != '0) state_d = ST_STALL;
        end
      end
      ST_STALL: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign waitrequest = (state_q == ST_STALL);

endmodule

// File: rtl/avmm_wr_checker.sv
// Avalon-MM write sink that checks an incrementing 16-bit pattern per address window
// and throttles the master with configurable WAITREQUEST stalls.
module avmm_wr_checker
  import avmm_chk_pkg::*;
#(
  parameter int          DATA_W    = 128,
  parameter int          ADDR_W    = 28,
  parameter int          SAMPLE_W  = 16,
  parameter int          N_WIN     = 3,
  parameter int          CNT_MAX   = 65535,
  parameter int          WAIT_MIN  = 10,
  parameter logic [7:0]  RAND_MASK = 8'h7F,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  AVS_WRITE,
  input  logic [ADDR_W-1:0]     AVS_ADDRESS,
  input  logic [DATA_W-1:0]     AVS_WRITEDATA,
  output logic                  AVS_WAITREQUEST,
  input  logic [1:0]            CFG_WAIT_MODE,
  input  logic [7:0]            CFG_WAIT_LEN,
  input  logic                  CFG_HALFSWAP,
  input  logic [ADDR_W-1:0]     CFG_WIN_BASE,
  input  logic [ADDR_W-1:0]     CFG_WIN_SIZE,
  input  logic                  CFG_LOAD,
  output logic                  ERR_FLAG,
  output logic [15:0]           ERR_CNT,
  output logic [2:0]            ERR_WIN,
  output logic [ADDR_W-1:0]     ERR_ADDR,
  output logic [SAMPLE_W-1:0]   ERR_EXP,
  output logic [SAMPLE_W-1:0]   ERR_GOT,
  output logic [15:0]           OOW_CNT,
  output logic [32*N_WIN-1:0]   WIN_BEATS
);

  localparam int LANES = DATA_W / SAMPLE_W;
  localparam int WORDS = DATA_W / 32;
  localparam int AW4   = ADDR_W + 4;
  localparam int WIN_W = 3;

  logic waitrequest;
  logic accept;

  avmm_wait_gen #(
    .WAIT_MIN  (WAIT_MIN),
    .RAND_MASK (RAND_MASK),
    .LFSR_SEED (LFSR_SEED)
  ) u_wait_gen (
    .clk         (CLK),
    .rst_n       (RST_N),
    .accept      (accept),
    .mode        (wait_mode_t'(CFG_WAIT_MODE)),
    .len         (CFG_WAIT_LEN),
    .waitrequest (waitrequest)
  );

  assign AVS_WAITREQUEST = waitrequest;
  assign accept          = AVS_WRITE & ~waitrequest;

  // Window decode in widened arithmetic so BASE + k*SIZE never wraps; lowest k wins.
  logic [AW4-1:0]   addr_ext, win_lo, win_hi;
  logic             dec_hit;
  logic [WIN_W-1:0] dec_win;

  always_comb begin
    addr_ext = {4'b0, AVS_ADDRESS};
    win_lo   = '0;
    win_hi   = '0;
    dec_hit  = 1'b0;
    dec_win  = '0;
    for (int k = N_WIN - 1; k >= 0; k--) begin
      win_lo = {4'b0, CFG_WIN_BASE} + AW4'(k) * {4'b0, CFG_WIN_SIZE};
      win_hi = win_lo + {4'b0, CFG_WIN_SIZE};
      if (addr_ext >= win_lo && addr_ext < win_hi) begin
        dec_hit = 1'b1;
        dec_win = WIN_W'(k);
      end
    end
  end

  logic                s1_valid_q, s1_valid_d;
  logic                s1_hit_q, s1_hit_d;
  logic [WIN_W-1:0]    s1_win_q, s1_win_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
  logic [DATA_W-1:0]   s1_data_q, s1_data_d;

  logic [SAMPLE_W-1:0] ref_q [N_WIN];
  logic [SAMPLE_W-1:0] ref_d [N_WIN];

  // Stage-2 lane compare against the selected window reference.
  logic [SAMPLE_W-1:0] ref_sel, lane_exp, mis_exp, mis_got;
  logic [DATA_W-1:0]   chk_data;
  logic                any_mis;

  always_comb begin
    ref_sel  = '0;
    chk_data = s1_data_q;
    lane_exp = '0;
    mis_exp  = '0;
    mis_got  = '0;
    any_mis  = 1'b0;
    for (int k = 0; k < N_WIN; k++) begin
      if (s1_win_q == WIN_W'(k)) ref_sel = ref_q[k];
    end
    if (CFG_HALFSWAP) begin
      for (int w = 0; w < WORDS; w++) chk_data[w*32 +: 32] = halfswap32(s1_data_q[w*32 +: 32]);
    end
    for (int j = 0; j < LANES; j++) begin
      lane_exp = SAMPLE_W'(exp_lane(32'(ref_sel), 32'(LANES - 1 - j), 32'(CNT_MAX)));
      if (chk_data[j*SAMPLE_W +: SAMPLE_W] != lane_exp) begin
        any_mis = 1'b1;
        mis_exp = lane_exp;
        mis_got = chk_data[j*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  logic                err_flag_q, err_flag_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [WIN_W-1:0]    err_win_q, err_win_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [SAMPLE_W-1:0] err_exp_q, err_exp_d;
  logic [SAMPLE_W-1:0] err_got_q, err_got_d;
  logic [15:0]         oow_cnt_q, oow_cnt_d;
  logic [32*N_WIN-1:0] win_beats_q, win_beats_d;

  always_comb begin
    s1_valid_d  = accept;
    s1_hit_d    = dec_hit;
    s1_win_d    = dec_win;
    s1_addr_d   = AVS_ADDRESS;
    s1_data_d   = AVS_WRITEDATA;
    err_flag_d  = err_flag_q;
    err_cnt_d   = err_cnt_q;
    err_win_d   = err_win_q;
    err_addr_d  = err_addr_q;
    err_exp_d   = err_exp_q;
    err_got_d   = err_got_q;
    oow_cnt_d   = oow_cnt_q;
    win_beats_d = win_beats_q;
    for (int k = 0; k < N_WIN; k++) ref_d[k] = ref_q[k];

    if (CFG_LOAD) begin
      // Rearm wins over any beat in flight, including one accepted this cycle.
      s1_valid_d  = 1'b0;
      err_flag_d  = 1'b0;
      err_cnt_d   = '0;
      err_win_d   = '0;
      err_addr_d  = '0;
      err_exp_d   = '0;
      err_got_d   = '0;
      oow_cnt_d   = '0;
      win_beats_d = '0;
      for (int k = 0; k < N_WIN; k++) ref_d[k] = '0;
    end else if (s1_valid_q) begin
      if (s1_hit_q) begin
        for (int k = 0; k < N_WIN; k++) begin
          if (s1_win_q == WIN_W'(k)) begin
            win_beats_d[k*32 +: 32] = win_beats_q[k*32 +: 32] + 32'd1;
            if (any_mis) ref_d[k] = SAMPLE_W'(exp_lane(32'(chk_data[SAMPLE_W-1:0]), 32'd1, 32'(CNT_MAX)));
            else         ref_d[k] = SAMPLE_W'(exp_lane(32'(ref_sel), 32'(LANES), 32'(CNT_MAX)));
          end
        end
        if (any_mis) begin
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          if (!err_flag_q) begin
            err_flag_d = 1'b1;
            err_win_d  = s1_win_q;
            err_addr_d = s1_addr_q;
            err_exp_d  = mis_exp;
            err_got_d  = mis_got;
          end
        end
      end else if (oow_cnt_q != 16'hFFFF) begin
        oow_cnt_d = oow_cnt_q + 16'd1;
      end
    end
  end

  // NOTE: the per-window reference array is a handful of flops, so it is reset like any other register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_q  <= 1'b0;
      s1_hit_q    <= 1'b0;
      s1_win_q    <= '0;
      s1_addr_q   <= '0;
      s1_data_q   <= '0;
      err_flag_q  <= 1'b0;
      err_cnt_q   <= '0;
      err_win_q   <= '0;
      err_addr_q  <= '0;
      err_exp_q   <= '0;
      err_got_q   <= '0;
      oow_cnt_q   <= '0;
      win_beats_q <= '0;
      for (int k = 0; k < N_WIN; k++) ref_q[k] <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_hit_q    <= s1_hit_d;
      s1_win_q    <= s1_win_d;
      s1_addr_q   <= s1_addr_d;
      s1_data_q   <= s1_data_d;
      err_flag_q  <= err_flag_d;
      err_cnt_q   <= err_cnt_d;
      err_win_q   <= err_win_d;
      err_addr_q  <= err_addr_d;
      err_exp_q   <= err_exp_d;
      err_got_q   <= err_got_d;
      oow_cnt_q   <= oow_cnt_d;
      win_beats_q <= win_beats_d;
      for (int k = 0; k < N_WIN; k++) ref_q[k] <= ref_d[k];
    end
  end

  assign ERR_FLAG  = err_flag_q;
  assign ERR_CNT   = err_cnt_q;
  assign ERR_WIN   = err_win_q;
  assign ERR_ADDR  = err_addr_q;
  assign ERR_EXP   = err_exp_q;
  assign ERR_GOT   = err_got_q;
  assign OOW_CNT   = oow_cnt_q;
  assign WIN_BEATS = win_beats_q;

endmodule

// File: doc/avmm_wr_checker.md
Name: avmm_wr_checker

Overview:
- Synthesizable Avalon-MM write-sink checker and SDRAM-port stall generator.
- Sits on the DMA writer's SDRAM0 port in place of the HPS SDRAM bridge, in both simulation and FPGA loopback builds.
- Checks the 16-bit incrementing test pattern independently in N_WIN consecutive address windows.
- Throttles the writer with none, fixed or pseudo-random WAITREQUEST stalls, and reports error/status counters.

Parameters:
- DATA_W, 128, write data width; multiple of 32.
- ADDR_W, 28, word address width.
- SAMPLE_W, 16, pattern sample width; LANES = DATA_W/SAMPLE_W.
- N_WIN, 3, number of checked windows (1..8).
- CNT_MAX, 65535, last pattern value before wrap to 0.
- WAIT_MIN, 10, minimum random stall length in cycles.
- RAND_MASK, 8'h7F, mask applied to LFSR bits [7:0] for the random stall part.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- CLK  in  1  bus clock; all logic in this domain.
- RST_N  in  1  asynchronous active-low reset.
- AVS_WRITE  in  1  write request.
- AVS_ADDRESS  in  ADDR_W  word address.
- AVS_WRITEDATA  in  DATA_W  write data.
- AVS_WAITREQUEST  out  1  stall to the master.
- CFG_WAIT_MODE  in  2  0 = none, 1 = fixed, 2 = random, 3 = reserved (treated as 0).
- CFG_WAIT_LEN  in  8  stall length for mode 1.
- CFG_HALFSWAP  in  1  swap 16-bit halves inside each 32-bit word before checking.
- CFG_WIN_BASE  in  ADDR_W  window 0 base address.
- CFG_WIN_SIZE  in  ADDR_W  size of each window in words.
- CFG_LOAD  in  1  one-cycle pulse: rearm the checker.
- ERR_FLAG  out  1  sticky; set on first mismatch.
- ERR_CNT  out  16  count of mismatching beats; saturates at FFFF.
- ERR_WIN  out  3  window of the first error.
- ERR_ADDR  out  ADDR_W  address of the first error.
- ERR_EXP  out  SAMPLE_W  expected value at the first error.
- ERR_GOT  out  SAMPLE_W  received value at the first error.
- OOW_CNT  out  16  accepted beats outside all windows; saturating.
- WIN_BEATS  out  32*N_WIN  per-window accepted-beat counters; wrap.

Behaviour:
- Clock and reset: one clock (CLK); asynchronous active-low reset (RST_N).
- Reset values: all outputs 0, AVS_WAITREQUEST = 0, all refs = 0, LFSR = LFSR_SEED, stall FSM in IDLE.
- Asserting RST_N low mid-stall drops WAITREQUEST immediately (asynchronously).
- A beat is accepted when AVS_WRITE & ~AVS_WAITREQUEST.
- Stall FSM:
  - IDLE: WAITREQUEST = 0. On an accepted beat, load cnt = len.
    - Mode 1: len = CFG_WAIT_LEN.
    - Mode 2: len = WAIT_MIN + (lfsr[7:0] & RAND_MASK).
    - Mode 0/3: len = 0.
    - If len > 0, go to STALL the next cycle.
  - STALL: WAITREQUEST = 1. cnt decrements each cycle; return to IDLE when cnt reaches 1. WAITREQUEST is therefore high for exactly len cycles.
  - A mode change during STALL does not affect the current stall.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle.
- Window decode (stage 1):
  - Window k hit when BASE + k*SIZE <= addr < BASE + (k+1)*SIZE.
  - Compute in ADDR_W+4 bits; no wrap.
  - Lowest k wins.
  - No hit: OOW_CNT += 1.
  - SIZE = 0: every beat counts as out-of-window.
- Pipeline: stage 1 registers data, address, window index and hit; stage 2 compares and updates status.
- Status latency: 2 cycles after acceptance. Back-to-back beats in the same window are supported through forwarding of the updated ref.
- Lane check:
  - Optional halfswap is applied first.
  - Lane j (LANES-1 down to 0) is expected to equal ref[k] + (LANES-1-j), modulo (CNT_MAX+1).
- Ref update after each beat:
  - Match: ref[k] += LANES (mod CNT_MAX+1).
  - Mismatch: resync ref[k] = lane 0 value + 1 (mod), ERR_CNT += 1 once per beat.
  - If ERR_FLAG was 0, set it and capture ERR_WIN, ERR_ADDR, and ERR_EXP/ERR_GOT of the highest mismatching lane.
- WIN_BEATS[k] increments on every in-window beat.
- CFG_LOAD: next cycle clears refs, ERR_*, OOW_CNT and WIN_BEATS, and flushes both pipeline stages. It does not touch the LFSR or the stall FSM.
- CFG_LOAD in the same cycle as an accepted beat: CFG_LOAD wins and the beat is not checked.
- CFG_WIN_* and CFG_HALFSWAP are sampled live; they must be changed only together with CFG_LOAD.

Decomposition:
- Package avmm_chk_pkg:
  - wait_mode_t enum.
  - LFSR tap constant.
  - Function exp_lane(ref, idx, cnt_max).
  - Function halfswap32.
- Sub-module avmm_wait_gen: LFSR plus stall FSM. Inputs: accept, mode, len; output: waitrequest.

Test Plan:
- Mode 0, BASE = 0, SIZE = 972: 972 beats of pattern 0..7775 -> ERR_CNT = 0, WIN_BEATS[0] = 972, WAITREQUEST never 1.
- Mode 1, LEN = 5: each accepted beat -> WAITREQUEST high exactly 5 cycles, starting the cycle after acceptance.
- Mode 2 after reset: stall lengths match the reference LFSR model and all lie in 10..137.
- Corrupt lane 3 of beat 4 (value +1) -> ERR_CNT = 1, ERR_EXP = 36, ERR_GOT = 37, ERR_ADDR = 4; following beats pass after resync.
- Pattern reaching 65535 -> wraps to 0 with no error.
- Beats to windows 0/1/2 interleaved plus address BASE + 3*SIZE -> independent refs stay error-free, OOW_CNT = 1.
- CFG_LOAD coincident with a bad beat -> ERR_CNT stays 0 and all counters read 0.
